// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: channel indices into the
// {c,l,r,u,d} vectors, 100 MHz default counts and the auto-repeat state type.
package btn_pkg;
  localparam int NUM_BTN = 5;
  localparam int IDX_C = 4;
  localparam int IDX_L = 3;
  localparam int IDX_R = 2;
  localparam int IDX_U = 1;
  localparam int IDX_D = 0;

  localparam int DEF_DEBOUNCE      = 1_000_000;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 20_000_000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;
endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, counter debounce and registered press pulse.
// rpt_i lets the parent fold auto-repeat strobes into the same output register.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic rpt_i,
  output logic level_o,
  output logic lvl_nxt_o,
  output logic pulse_o
);
  localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == DB_LAST) level_d = s2_q;
      else                  cnt_d   = cnt_q + DW'(1);
    end
    // Only the 0->1 level change is a press; releases stay silent.
    pulse_d = (~level_q & level_d) | rpt_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o   = level_q;
  assign lvl_nxt_o = level_d;
  assign pulse_o   = pulse_q;
endmodule

// File: rtl/button_conditioner.sv
// Five debounced push-buttons with single-cycle press pulses; up and down
// auto-repeat while held so the adjust logic keeps stepping.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_c,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               btn_u,
  input  logic               btn_d,
  output logic               c,
  output logic               l,
  output logic               r,
  output logic               u,
  output logic               d,
  output logic [NUM_BTN-1:0] btn_level
);
  localparam int             RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int             CW          = $clog2(RMAX + 1);
  localparam bit             RPT_EN      = (REPEAT_DELAY > 0);
  localparam logic [CW-1:0] DELAY_LOAD  = RPT_EN ? CW'(REPEAT_DELAY - 1) : '0;
  localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] raw, pulse;

  assign raw = {btn_c, btn_l, btn_r, btn_u, btn_d};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic lvl, lvl_nxt, rpt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (raw[i]),
      .rpt_i     (rpt),
      .level_o   (lvl),
      .lvl_nxt_o (lvl_nxt),
      .pulse_o   (pulse[i])
    );

    assign btn_level[i] = lvl;

    if (i == IDX_U || i == IDX_D) begin : g_rpt
      rpt_state_e    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= RPT_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Release wins over an expiring counter so no strobe leaks on the release edge.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt     = 1'b0;
        unique case (state_q)
          RPT_IDLE: begin
            if (RPT_EN && !lvl && lvl_nxt) begin
              state_d = RPT_DELAY;
              cnt_d   = DELAY_LOAD;
            end
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (!lvl_nxt) begin
              state_d = RPT_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == '0) begin
              rpt     = 1'b1;
              state_d = RPT_REPEAT;
              cnt_d   = PERIOD_LOAD;
            end else begin
              cnt_d   = cnt_q - CW'(1);
            end
          end
          default: state_d = RPT_IDLE;
        endcase
      end
    end else begin : g_norpt
      logic unused_lvl_nxt;
      assign unused_lvl_nxt = lvl_nxt;
      assign rpt            = 1'b0;
    end
  end

  assign {c, l, r, u, d} = pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed scenarios for button_conditioner; expected pulses are queued by the
// stimulus and matched by an independent monitor on every observed pulse.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  typedef struct {
    int         at;
    logic [4:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       c, l, r, u, d;
  logic [4:0] btn_level;
  logic [4:0] pulses;

  exp_t exp_q[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   base = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_c    (btn_c),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .btn_u    (btn_u),
    .btn_d    (btn_d),
    .c        (c),
    .l        (l),
    .r        (r),
    .u        (u),
    .d        (d),
    .btn_level(btn_level)
  );

  assign pulses = {c, l, r, u, d};

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n - base);
  endtask

  // Monitor: any visible pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (pulses != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(pulses), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_edge", edge_n - base, mon_e.at - base);
        check("pulse_mask", int'(pulses), int'(mon_e.mask));
      end
    end
  end

  task automatic go_to(input int n);
    while (edge_n < base + n) @(negedge clk);
  endtask

  task automatic start();
    @(negedge clk);
    base = edge_n;
  endtask

  task automatic expect_pulse(input int n, input logic [4:0] m);
    exp_t e;
    e.at   = base + n;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_level", int'(btn_level), 0);
    check("rst_pulse", int'(pulses), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    #1 rst_n = 1'b0;

    // Clean press and release on centre.
    do_reset();
    start();
    btn_c = 1'b1;
    expect_pulse(6, 5'b10000);
    go_to(5);  check("c_level_e5", int'(btn_level[4]), 0);
    go_to(6);  check("c_level_e6", int'(btn_level[4]), 1);
    go_to(20); btn_c = 1'b0;
    go_to(25); check("c_rel_e25", int'(btn_level[4]), 1);
    go_to(26); check("c_rel_e26", int'(btn_level[4]), 0);
    go_to(30); check("c_queue_empty", exp_q.size(), 0);

    // Bouncing left: 1,0,1,0,1,0,0,0 then steady high from edge 9.
    do_reset();
    start();
    pat = 8'b1010_1000;
    expect_pulse(14, 5'b01000);
    for (int k = 0; k < 8; k++) begin
      go_to(k);
      btn_l = pat[7-k];
    end
    go_to(8);  btn_l = 1'b1;
    go_to(13); check("l_level_e13", int'(btn_level[3]), 0);
    go_to(14); check("l_level_e14", int'(btn_level[3]), 1);
    go_to(24); btn_l = 1'b0;
    go_to(34); check("l_rel_level", int'(btn_level[3]), 0);
    check("l_queue_empty", exp_q.size(), 0);

    // Auto-repeat on down, released before edge 31.
    do_reset();
    start();
    btn_d = 1'b1;
    expect_pulse(6,  5'b00001);
    expect_pulse(16, 5'b00001);
    expect_pulse(21, 5'b00001);
    expect_pulse(26, 5'b00001);
    expect_pulse(31, 5'b00001);
    go_to(30); btn_d = 1'b0;
    go_to(35); check("d_level_e35", int'(btn_level[0]), 1);
    go_to(36); check("d_level_e36", int'(btn_level[0]), 0);
    go_to(50); check("d_queue_empty", exp_q.size(), 0);

    // Simultaneous right + up; long right hold must not repeat.
    do_reset();
    start();
    btn_r = 1'b1;
    btn_u = 1'b1;
    expect_pulse(6, 5'b00110);
    go_to(6);  check("ru_level_e6", int'(btn_level), 6);
    go_to(7);  btn_u = 1'b0;
    go_to(40); btn_r = 1'b0;
    go_to(50); check("ru_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-press on up.
    do_reset();
    start();
    btn_u = 1'b1;
    go_to(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_level", int'(btn_level), 0);
    check("mid_rst_pulse", int'(pulses), 0);
    go_to(5);  rst_n = 1'b1;
    expect_pulse(11, 5'b00010);
    go_to(12); btn_u = 1'b0;
    go_to(30); check("u_rst_queue_empty", exp_q.size(), 0);

    // Centre held through reset: level clears at once, then a fresh press.
    do_reset();
    start();
    btn_c = 1'b1;
    expect_pulse(6, 5'b10000);
    go_to(8);  check("hold_level_pre", int'(btn_level[4]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("hold_level_async", int'(btn_level), 0);
    go_to(10); rst_n = 1'b1;
    expect_pulse(16, 5'b10000);
    go_to(15); check("hold_level_e15", int'(btn_level[4]), 0);
    go_to(20); btn_c = 1'b0;
    go_to(30); check("hold_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1);
  end
endmodule
